ahb_rr_burst_arbiter: RTL and testbench

//  Burst-aware round-robin AHB-Lite arbiter for N bus masters.
//  It tracks fixed-length bursts with a beat counter, so a grant never moves mid-burst.
//  It honours HLOCK, aborts on ERROR/RETRY/SPLIT, and parks on a default master.
//  It sits between the master request lines and the AHB master mux; HMASTER steers the mux.

---
 rtl/ahb_pkg.sv | 47 ++++
 rtl/rr_pick.sv | 45 ++++
 rtl/ahb_rr_burst_arbiter.sv | 136 +++++++++++++
 tb/tb_ahb_rr_burst_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and arbiter state type for the round-robin burst arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'd0,
    BU_INCR   = 3'd1,
    BU_WRAP4  = 3'd2,
    BU_INCR4  = 3'd3,
    BU_WRAP8  = 3'd4,
    BU_INCR8  = 3'd5,
    BU_WRAP16 = 3'd6,
    BU_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    RSP_OKAY  = 2'd0,
    RSP_ERROR = 2'd1,
    RSP_RETRY = 2'd2,
    RSP_SPLIT = 2'd3
  } hresp_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  localparam int unsigned BEAT_W = 4;

  // Remaining SEQ beats after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
  function automatic logic [BEAT_W-1:0] burst_beats(hburst_e b);
    case (b)
      BU_WRAP4, BU_INCR4:   burst_beats = 4'd3;
      BU_WRAP8, BU_INCR8:   burst_beats = 4'd7;
      BU_WRAP16, BU_INCR16: burst_beats = 4'd15;
      default:              burst_beats = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping around to ptr itself.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] req_hi;
  logic         found;

  // Lower half of the doubled vector keeps only requests above ptr; upper half is unmasked.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < int'(N); i++) begin
      hi_mask[i] = (i > int'(ptr));
    end
  end

  assign req_hi = req & hi_mask;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req_hi[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/ahb_rr_burst_arbiter.sv
// Burst-aware round-robin AHB-Lite arbiter: grant never moves mid fixed burst, honours HLOCK,
// re-arbitrates on ERROR/RETRY/SPLIT and parks on DEFAULT_MASTER.
module ahb_rr_burst_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned MASTER_BITS    = $clog2(N_MASTERS),
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [N_MASTERS-1:0]   HBUSREQ,
  input  logic [N_MASTERS-1:0]   HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [N_MASTERS-1:0]   HGRANT,
  output logic [MASTER_BITS-1:0] HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [N_MASTERS-1:0]   DEF_GNT = N_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MASTER_BITS-1:0] DEF_IDX = MASTER_BITS'(DEFAULT_MASTER);

  arb_state_e             state, state_nxt, eff_state;
  logic [BEAT_W-1:0]      beat_cnt, cnt_nxt, beats;
  logic [MASTER_BITS-1:0] rr_ptr, ptr_nxt, owner_idx, pick_idx;
  logic [N_MASTERS-1:0]   gnt_nxt, pick_gnt, arb_gnt;
  logic                   pick_valid, owner_req, owner_lock, abort, rearb;
  htrans_e                trans;
  hburst_e                burst;
  hresp_e                 resp;

  // Lowest set bit wins; a legal one-hot grant has exactly one.
  function automatic logic [MASTER_BITS-1:0] onehot_idx(logic [N_MASTERS-1:0] v);
    onehot_idx = DEF_IDX;
    for (int i = int'(N_MASTERS) - 1; i >= 0; i--) begin
      if (v[i]) onehot_idx = MASTER_BITS'(i);
    end
  endfunction

  assign trans      = htrans_e'(HTRANS);
  assign burst      = hburst_e'(HBURST);
  assign resp       = hresp_e'(HRESP);
  assign beats      = burst_beats(burst);
  assign owner_req  = |(HGRANT & HBUSREQ);
  assign owner_lock = |(HGRANT & HLOCK);
  assign abort      = (resp != RSP_OKAY);
  assign owner_idx  = onehot_idx(HGRANT);
  assign pick_idx   = onehot_idx(pick_gnt);
  assign arb_gnt    = pick_valid ? pick_gnt : DEF_GNT;

  rr_pick #(
    .N  (N_MASTERS),
    .PW (MASTER_BITS)
  ) u_pick (
    .req   (HBUSREQ),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Next state: LOCKED tracks beats like the state it will return to, then lock overrides.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    gnt_nxt   = HGRANT;
    ptr_nxt   = rr_ptr;
    rearb     = 1'b0;
    eff_state = state;
    if (state == LOCKED) eff_state = (beat_cnt != '0) ? BURST : ARB;

    case (eff_state)
      BURST: begin
        state_nxt = BURST;
        if (trans == TR_NONSEQ && beats != '0) begin
          cnt_nxt = beats;
        end else if (trans == TR_SEQ) begin
          if (beat_cnt <= 4'd1) begin
            cnt_nxt   = '0;
            state_nxt = ARB;
            rearb     = 1'b1;
          end else begin
            cnt_nxt = beat_cnt - 4'd1;
          end
        end
      end
      default: begin
        state_nxt = ARB;
        if (trans == TR_NONSEQ && beats != '0) begin
          cnt_nxt   = beats;
          state_nxt = BURST;
        end else if (!(owner_req && trans != TR_IDLE)) begin
          rearb = 1'b1;
        end
      end
    endcase

    if (abort) begin
      cnt_nxt   = '0;
      state_nxt = ARB;
      rearb     = 1'b1;
    end

    if (owner_lock) begin
      state_nxt = LOCKED;
      rearb     = 1'b0;
    end

    if (rearb) begin
      gnt_nxt = arb_gnt;
      if (pick_valid) ptr_nxt = pick_idx;
    end
  end

  // Every register advances only on HREADY; wait states freeze the whole arbiter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ARB;
      beat_cnt  <= '0;
      rr_ptr    <= DEF_IDX;
      HGRANT    <= DEF_GNT;
      HMASTER   <= DEF_IDX;
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      state     <= state_nxt;
      beat_cnt  <= cnt_nxt;
      rr_ptr    <= ptr_nxt;
      HGRANT    <= gnt_nxt;
      HMASTER   <= owner_idx;
      HMASTLOCK <= owner_lock;
    end
  end

endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
// Directed bench for ahb_rr_burst_arbiter (N=4, DEFAULT_MASTER=0): vector table plus burst/lock/abort sequences.
module tb_ahb_rr_burst_arbiter;
  import ahb_pkg::*;

  logic       HCLK;
  logic       HRESETn;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HRESP;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int total = 0;
  int bad   = 0;

  ahb_rr_burst_arbiter #(
    .N_MASTERS      (4),
    .MASTER_BITS    (2),
    .DEFAULT_MASTER (0)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [3:0] busreq;
    logic [3:0] lock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;
    logic [3:0] gnt;
    logic [1:0] mst;
    logic       mlock;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] br, logic [1:0] tr, logic [2:0] bu,
                              logic [3:0] gnt, logic [1:0] mst);
    vec_t v;
    v.busreq = br;  v.lock = 4'b0000; v.htrans = tr; v.hburst = bu;
    v.hready = 1'b1; v.hresp = RSP_OKAY;
    v.gnt = gnt; v.mst = mst; v.mlock = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] br, input logic [3:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy, input logic [1:0] rsp);
    HBUSREQ = br; HLOCK = lk; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rsp;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0;
    drive(4'b0000, 4'b0000, TR_IDLE, BU_SINGLE, 1'b1, RSP_OKAY);
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_gnt", 32'(HGRANT), 32'h1);
    chk("rst_mst", 32'(HMASTER), 32'h0);
    chk("rst_mlock", 32'(HMASTLOCK), 32'h0);
    chk("rst_state", 32'(dut.state), 32'(ARB));
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Idle parking, full rotation, INCR4 hold and handover
    vecs.push_back(mk(4'b0000, TR_IDLE,   BU_SINGLE, 4'b0001, 2'd0));
    vecs.push_back(mk(4'b0000, TR_IDLE,   BU_SINGLE, 4'b0001, 2'd0));
    vecs.push_back(mk(4'b0000, TR_IDLE,   BU_SINGLE, 4'b0001, 2'd0));
    vecs.push_back(mk(4'b1111, TR_IDLE,   BU_SINGLE, 4'b0010, 2'd0));
    vecs.push_back(mk(4'b1111, TR_IDLE,   BU_SINGLE, 4'b0100, 2'd1));
    vecs.push_back(mk(4'b1111, TR_IDLE,   BU_SINGLE, 4'b1000, 2'd2));
    vecs.push_back(mk(4'b1111, TR_IDLE,   BU_SINGLE, 4'b0001, 2'd3));
    vecs.push_back(mk(4'b1111, TR_IDLE,   BU_SINGLE, 4'b0010, 2'd0));
    vecs.push_back(mk(4'b0100, TR_IDLE,   BU_SINGLE, 4'b0100, 2'd1));
    vecs.push_back(mk(4'b1110, TR_NONSEQ, BU_INCR4,  4'b0100, 2'd2));
    vecs.push_back(mk(4'b1110, TR_SEQ,    BU_INCR4,  4'b0100, 2'd2));
    vecs.push_back(mk(4'b1110, TR_SEQ,    BU_INCR4,  4'b0100, 2'd2));
    vecs.push_back(mk(4'b1110, TR_SEQ,    BU_INCR4,  4'b1000, 2'd2));
    vecs.push_back(mk(4'b0000, TR_IDLE,   BU_SINGLE, 4'b0001, 2'd3));
    vecs.push_back(mk(4'b0000, TR_IDLE,   BU_SINGLE, 4'b0001, 2'd0));

    foreach (vecs[i]) begin
      drive(vecs[i].busreq, vecs[i].lock, vecs[i].htrans, vecs[i].hburst,
            vecs[i].hready, vecs[i].hresp);
      step();
      chk($sformatf("vec%0d_gnt", i), 32'(HGRANT), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d_mst", i), 32'(HMASTER), 32'(vecs[i].mst));
      chk($sformatf("vec%0d_mlock", i), 32'(HMASTLOCK), 32'(vecs[i].mlock));
    end

    // INCR8 by parked master 0 with wait states, a BUSY beat and the owner dropping its request
    drive(4'b1011, 4'b0000, TR_NONSEQ, BU_INCR8, 1'b1, RSP_OKAY);
    step();
    chk("s4_load_cnt", 32'(dut.beat_cnt), 32'd7);
    chk("s4_load_gnt", 32'(HGRANT), 32'h1);
    drive(4'b1010, 4'b0000, TR_SEQ, BU_INCR8, 1'b1, RSP_OKAY);
    repeat (2) step();
    chk("s4_seq2_cnt", 32'(dut.beat_cnt), 32'd5);
    drive(4'b1010, 4'b0000, TR_SEQ, BU_INCR8, 1'b0, RSP_OKAY);
    repeat (2) step();
    chk("s4_wait_cnt", 32'(dut.beat_cnt), 32'd5);
    chk("s4_wait_gnt", 32'(HGRANT), 32'h1);
    drive(4'b1010, 4'b0000, TR_BUSY, BU_INCR8, 1'b1, RSP_OKAY);
    step();
    chk("s4_busy_cnt", 32'(dut.beat_cnt), 32'd5);
    drive(4'b1010, 4'b0000, TR_SEQ, BU_INCR8, 1'b1, RSP_OKAY);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 4) chk($sformatf("s4_hold%0d_gnt", k), 32'(HGRANT), 32'h1);
    end
    chk("s4_handover_gnt", 32'(HGRANT), 32'b0010);
    chk("s4_handover_cnt", 32'(dut.beat_cnt), 32'd0);
    chk("s4_handover_mst", 32'(HMASTER), 32'd0);

    // Master 1 locked across two INCR4 bursts while master 3 requests
    for (int b = 0; b < 2; b++) begin
      drive(4'b1010, 4'b0010, TR_NONSEQ, BU_INCR4, 1'b1, RSP_OKAY);
      step();
      chk($sformatf("s5_b%0d_ns_gnt", b), 32'(HGRANT), 32'b0010);
      chk($sformatf("s5_b%0d_ns_mlock", b), 32'(HMASTLOCK), 32'h1);
      drive(4'b1010, 4'b0010, TR_SEQ, BU_INCR4, 1'b1, RSP_OKAY);
      for (int k = 0; k < 3; k++) begin
        step();
        chk($sformatf("s5_b%0d_s%0d_gnt", b, k), 32'(HGRANT), 32'b0010);
        chk($sformatf("s5_b%0d_s%0d_mlock", b, k), 32'(HMASTLOCK), 32'h1);
      end
    end
    chk("s5_state", 32'(dut.state), 32'(LOCKED));
    drive(4'b1000, 4'b0000, TR_IDLE, BU_SINGLE, 1'b1, RSP_OKAY);
    step();
    chk("s5_rel_gnt", 32'(HGRANT), 32'b1000);
    chk("s5_rel_mlock", 32'(HMASTLOCK), 32'h0);
    chk("s5_rel_mst", 32'(HMASTER), 32'd1);
    step();
    chk("s5_after_mst", 32'(HMASTER), 32'd3);

    // RETRY on the second beat of WRAP8, acted on only in the HREADY cycle
    drive(4'b1001, 4'b0000, TR_NONSEQ, BU_WRAP8, 1'b1, RSP_OKAY);
    step();
    drive(4'b1001, 4'b0000, TR_SEQ, BU_WRAP8, 1'b1, RSP_OKAY);
    step();
    chk("s6_beat2_cnt", 32'(dut.beat_cnt), 32'd6);
    drive(4'b1100, 4'b0000, TR_SEQ, BU_WRAP8, 1'b0, RSP_RETRY);
    step();
    chk("s6_retry1_cnt", 32'(dut.beat_cnt), 32'd6);
    chk("s6_retry1_gnt", 32'(HGRANT), 32'b1000);
    drive(4'b1100, 4'b0000, TR_IDLE, BU_WRAP8, 1'b1, RSP_RETRY);
    step();
    chk("s6_retry2_state", 32'(dut.state), 32'(ARB));
    chk("s6_retry2_cnt", 32'(dut.beat_cnt), 32'd0);
    chk("s6_retry2_gnt", 32'(HGRANT), 32'b0100);

    // Reset pulse mid locked INCR16
    drive(4'b0100, 4'b0100, TR_NONSEQ, BU_INCR16, 1'b1, RSP_OKAY);
    step();
    drive(4'b0100, 4'b0100, TR_SEQ, BU_INCR16, 1'b1, RSP_OKAY);
    step();
    chk("s6_i16_cnt", 32'(dut.beat_cnt), 32'd14);
    chk("s6_i16_mlock", 32'(HMASTLOCK), 32'h1);
    chk("s6_i16_mst", 32'(HMASTER), 32'd2);
    #3;
    HRESETn = 1'b0;
    #1;
    chk("s6_rst_gnt", 32'(HGRANT), 32'h1);
    chk("s6_rst_mst", 32'(HMASTER), 32'h0);
    chk("s6_rst_mlock", 32'(HMASTLOCK), 32'h0);
    chk("s6_rst_state", 32'(dut.state), 32'(ARB));
    chk("s6_rst_cnt", 32'(dut.beat_cnt), 32'd0);
    drive(4'b1111, 4'b0000, TR_IDLE, BU_SINGLE, 1'b1, RSP_OKAY);
    #2;
    HRESETn = 1'b1;
    step();
    chk("s6_post_rst_gnt", 32'(HGRANT), 32'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
